mul_hilo_ctrl: RTL

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

---
 rtl/mul_hilo_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: HI/LO sequencing around an external unsigned multiplier.
// Define MUL_SIGNED_EN to enable signed operands; otherwise op_signed is ignored.
module mul_hilo_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic neg, sgn, last, load;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod;
`ifdef MUL_SIGNED_EN
  assign sgn = op_signed;
`else
  assign sgn = op_signed & 1'b0;
`endif
  // negating 0x80000000 wraps back to itself, which is the required magnitude
  assign mag_a = (sgn & a[31]) ? -a : a;
  assign mag_b = (sgn & b[31]) ? -b : b;
  assign prod  = {mul_hi, mul_lo};
  assign load  = (state == IDLE) && start;
  assign last  = (state == WAIT) && (cnt == 4'(LATENCY - 1));
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (start ? WAIT : IDLE) :
           state == WAIT ? (last ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      neg   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load) begin
        mul_a <= mag_a;
        mul_b <= mag_b;
        neg   <= sgn & (a[31] ^ b[31]);
        cnt   <= '0;
      end else if (state == IDLE && hilo_we) begin
        if (hilo_sel) hi <= hilo_wdata;
        else lo <= hilo_wdata;
      end
      if (state == WAIT) cnt <= cnt + 4'd1;
      if (last) {hi, lo} <= neg ? -prod : prod;
    end
endmodule
